addsub_serial: RTL and testbench
================================

# addsub_serial

Bit-serial adder/subtractor that computes a WIDTH-bit sum or difference LSB-first, one bit per clock. It uses a single 1-bit full adder/subtractor cell and a carry/borrow register. It is the sequential counterpart to the combinational per-bit add/subtract cell. It sits between a register-file or controller front end, which issues operands with `start`, and any consumer that waits on `done`.

## Interface

- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.
- `clk`  input  1  sole clock; rising edge.
- `resetN`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only in IDLE.
- `modeAddSubtract`  input  1  0 = ADD (a + b + carryIn), 1 = SUBTRACT (a − b − borrowIn); captured with `start`.
- `a`  input  WIDTH  operand A, captured with `start`.
- `b`  input  WIDTH  operand B, captured with `start`.
- `carryborrowIn`  input  1  carry in (ADD) or borrow in (SUB), captured with `start`.
- `busy`  output  1  high in RUN and DONE.
- `done`  output  1  one-cycle pulse; result is valid.
- `result`  output  WIDTH  sum or difference; held until the next accepted `start`.
- `carryborrowOut`  output  1  final carry (ADD) or borrow (SUB); held with `result`.
- `overflow`  output  1  signed overflow; present only with the macro.

## Operation

- States are IDLE, RUN and DONE. A bit counter runs 0..WIDTH−1.
- **IDLE** with `start`=1: latch `a` and `b` into shift registers, latch the mode, load the carry register with `carryborrowIn`, clear the counter, go to RUN.
- **IDLE** with `start`=0: stay in IDLE.
- **RUN**, each cycle: feed the cell with aSh[0], bSh[0], carry register and mode.
  - Shift the result bit into the MSB of the result shift register.
  - Shift aSh and bSh right.
  - Update the carry register.
  - Increment the counter.
  - When the counter is WIDTH−1, go to DONE.
- Cell equations, per bit:
  - ADD: s = a⊕b⊕c; cOut = ab | c(a⊕b).
  - SUB: d = a⊕b⊕c; bOut = (~a)b | c·~(a⊕b).
- Arithmetic is unsigned modulo 2^WIDTH. `carryborrowOut` = 1 on ADD when the true sum ≥ 2^WIDTH. On SUB it is 1 when a < b + borrowIn.
- **DONE**: assert `done` for one cycle. `result` and `carryborrowOut` are stable. Next state is IDLE unconditionally.
- `start` in RUN or DONE is ignored and not queued.
- Input changes after capture have no effect on the operation in progress.

## Timing

- Reset values: state IDLE; `busy`, `done`, `result`, `carryborrowOut` and `overflow` all 0; internal registers 0.
- Reset is asynchronous and may occur mid-operation. It aborts immediately to the reset values. No `done` is produced for the aborted operation.
- Accept: `start` is sampled at rising edge E0 while in IDLE.
- `busy` rises in the cycle after E0.
- The RUN phase spans WIDTH cycles.
- `done`=1 in cycle WIDTH+1 after E0. `busy` is also 1 in that cycle.
- IDLE is entered WIDTH+2 cycles after E0. A new `start` can be accepted at that edge. Throughput is one operation per WIDTH+2 cycles.
- `result` and `carryborrowOut` update only at the DONE transition. They never show partial values.

## Configuration

- Macro: `ADDSUB_SERIAL_OVERFLOW_EN`.
- Defined:
  - Add the `overflow` port.
  - At the final RUN bit, register overflow = (carry into MSB) ⊕ (carry/borrow out of MSB).
  - `overflow` has the same validity and hold behaviour as `carryborrowOut`.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Structure

- Package `addsub_serial_pkg`:
  - state enum (IDLE, RUN, DONE);
  - constants MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
- Sub-module `addsub_bit_cell`: the combinational 1-bit add/subtract cell.
  - Inputs: mode, a, b, cIn.
  - Outputs: s, cOut.
  - Instantiated once.
- The top level holds the FSM, counter, shift registers and the carry flop.

## Test plan

- ADD, a=0x5A, b=0x3C, cin=0 → `done` at cycle 9 after the start edge; result=0x96, carryborrowOut=0, overflow=1.
- ADD, a=0xFF, b=0x01, cin=0 → result=0x00, carryborrowOut=1, overflow=0. ADD, a=0x01, b=0x01, cin=1 → result=0x03.
- SUB, a=0x10, b=0x20, bin=0 → result=0xF0, carryborrowOut=1, overflow=0. SUB, a=0x80, b=0x01 → result=0x7F, carryborrowOut=0, overflow=1.
- Hold `start`=1 continuously with a new operand every cycle → exactly one `done` per 10 cycles. Each result matches the operands present at its accept edge.
- Assert `resetN`=0 at RUN bit 4 → `busy` and `result` read 0 immediately; no `done`. After release, ADD 0x02+0x03 → 0x05.
- Without the macro: same vectors give identical `result` and `carryborrowOut`; the `overflow` port is absent.

Source files
------------

// File: rtl/addsub_serial_pkg.sv
// addsub_serial_pkg: shared types and constants for the bit-serial
// adder/subtractor.
//   state_t  : FSM state encoding (IDLE, RUN, DONE)
//   MODE_ADD : mode value selecting a + b + carryIn
//   MODE_SUB : mode value selecting a - b - borrowIn
package addsub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_bit_cell.sv
// addsub_bit_cell: combinational 1-bit full adder / full subtractor.
// Ports:
//   mode : MODE_ADD or MODE_SUB
//   a, b : operand bits
//   cIn  : carry in (add) or borrow in (subtract)
//   s    : sum / difference bit
//   cOut : carry out (add) or borrow out (subtract)
module addsub_bit_cell
  import addsub_serial_pkg::*;
(
  input  logic mode,
  input  logic a,
  input  logic b,
  input  logic cIn,
  output logic s,
  output logic cOut
);

  logic p;

  always_comb begin
    p = a ^ b;
    s = p ^ cIn;
    if (mode == MODE_SUB) begin
      cOut = (~a & b) | (cIn & ~p);
    end else begin
      cOut = (a & b) | (cIn & p);
    end
  end

endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: bit-serial WIDTH-bit adder/subtractor, LSB first, one bit
// per clock through a single addsub_bit_cell and a carry/borrow flop.
// Optional feature macro: ADDSUB_SERIAL_OVERFLOW_EN adds the signed
// overflow output.
// Ports:
//   clk             : rising-edge clock
//   resetN          : asynchronous active-low reset
//   start           : request, sampled only in IDLE
//   modeAddSubtract : 0 = add, 1 = subtract (captured with start)
//   a, b            : operands (captured with start)
//   carryborrowIn   : carry/borrow in (captured with start)
//   busy            : high in RUN and DONE
//   done            : one-cycle pulse, result valid
//   result          : sum/difference, held until the next accepted start
//   carryborrowOut  : final carry/borrow, held with result
//   overflow        : signed overflow (macro only), held with result
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic             modeAddSubtract,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryborrowIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef ADDSUB_SERIAL_OVERFLOW_EN
  output logic             carryborrowOut,
  output logic             overflow
`else
  output logic             carryborrowOut
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  // Partial-result register holds only the WIDTH-1 low bits; the MSB comes
  // straight from the cell on the final bit, so result never shows partials.
  localparam int RW    = WIDTH - 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [RW-1:0]      r_sh;
  logic               mode_q;
  logic               c_q;
  logic               s_bit;
  logic               c_out;

  addsub_bit_cell u_cell (
    .mode (mode_q),
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cIn  (c_q),
    .s    (s_bit),
    .cOut (c_out)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= IDLE;
      cnt            <= '0;
      a_sh           <= '0;
      b_sh           <= '0;
      r_sh           <= '0;
      mode_q         <= MODE_ADD;
      c_q            <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      result         <= '0;
      carryborrowOut <= 1'b0;
`ifdef ADDSUB_SERIAL_OVERFLOW_EN
      overflow       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            mode_q <= modeAddSubtract;
            c_q    <= carryborrowIn;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          r_sh <= (r_sh >> 1) | (RW'(s_bit) << (RW - 1));
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          c_q  <= c_out;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            result         <= {s_bit, r_sh};
            carryborrowOut <= c_out;
`ifdef ADDSUB_SERIAL_OVERFLOW_EN
            // c_q is the carry/borrow into the MSB at this point.
            overflow       <= c_q ^ c_out;
`endif
            done           <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: self-checking bench for addsub_serial (WIDTH = 8).
// Expected results come from an arithmetic model, pushed to a queue when an
// operation is issued and popped when the DUT pulses done.
module tb_addsub_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cbo;
`ifdef ADDSUB_SERIAL_OVERFLOW_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_result = '0;

  addsub_serial #(.WIDTH(W)) dut (
    .clk             (clk),
    .resetN          (resetN),
    .start           (start),
    .modeAddSubtract (mode),
    .a               (a),
    .b               (b),
    .carryborrowIn   (cin),
    .busy            (busy),
    .done            (done),
    .result          (result),
`ifdef ADDSUB_SERIAL_OVERFLOW_EN
    .carryborrowOut  (cbo),
    .overflow        (ovf)
`else
    .carryborrowOut  (cbo)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(logic m, logic [W-1:0] x, logic [W-1:0] y, logic ci);
    exp_t       e;
    logic [W:0] t;
    if (m == 1'b0) begin
      t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      e.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    end else begin
      t   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
      e.v = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
    end
    e.r = t[W-1:0];
    e.c = t[W];
    return e;
  endfunction

  // Drive one request, hold it across the accept edge, then scramble inputs.
  task automatic issue(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci);
    @(negedge clk);
    mode  = m;
    a     = x;
    b     = y;
    cin   = ci;
    start = 1'b1;
    q.push_back(model(m, x, y, ci));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    mode  = 1'($urandom);
    cin   = 1'($urandom);
  endtask

  // Returns the cycle (1 = cycle after accept edge) done was seen, 0 on timeout;
  // held is cleared if result moved before done.
  task automatic wait_done(output int cyc, output logic held);
    cyc  = 0;
    held = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = k;
        return;
      end
      if (result !== last_result) held = 1'b0;
    end
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, result, cbo} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b result=%h cbo=%b required all 0",
               busy, done, result, cbo);
    end
`ifdef ADDSUB_SERIAL_OVERFLOW_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow got %b required 0", ovf);
    end
`endif
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done);
    end
    last_result = '0;
  endtask

  task automatic run_table(input string name, input logic m,
                           input logic [W-1:0] xs[6], input logic [W-1:0] ys[6],
                           input logic cs[6]);
    int   cyc;
    logic held;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue(m, xs[i], ys[i], cs[i]);
      wait_done(cyc, held);
      checks++;
      if (cyc != W + 1) begin
        errors++;
        $display("FAIL %s_latency[%0d] got cycle %0d required %0d", name, i, cyc, W + 1);
      end
      checks++;
      if (!held) begin
        errors++;
        $display("FAIL %s_partial[%0d] result changed before done, required held %h",
                 name, i, last_result);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy_at_done[%0d] got %b required 1", name, i, busy);
      end
      if (q.size() == 0) begin
        errors++;
        $display("FAIL %s_queue[%0d] empty at done", name, i);
        continue;
      end
      e = q.pop_front();
      checks++;
      if (result !== e.r || cbo !== e.c) begin
        errors++;
        $display("FAIL %s_result[%0d] a=%h b=%h c=%b got %h/%b required %h/%b",
                 name, i, xs[i], ys[i], cs[i], result, cbo, e.r, e.c);
      end
`ifdef ADDSUB_SERIAL_OVERFLOW_EN
      checks++;
      if (ovf !== e.v) begin
        errors++;
        $display("FAIL %s_overflow[%0d] got %b required %b", name, i, ovf, e.v);
      end
`endif
      last_result = e.r;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== e.r) begin
        errors++;
        $display("FAIL %s_after_done[%0d] done=%b busy=%b result=%h required 0 0 %h",
                 name, i, done, busy, result, e.r);
      end
    end
  endtask

  task automatic test_add;
    logic [W-1:0] xs[6];
    logic [W-1:0] ys[6];
    logic         cs[6];
    xs = '{8'h5A, 8'hFF, 8'h01, 8'h00, 8'h7F, 8'hC3};
    ys = '{8'h3C, 8'h01, 8'h01, 8'h00, 8'h01, 8'hA5};
    cs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 4; i < 6; i++) begin
      xs[i] = W'($urandom);
      ys[i] = W'($urandom);
    end
    run_table("add", 1'b0, xs, ys, cs);
  endtask

  task automatic test_sub;
    logic [W-1:0] xs[6];
    logic [W-1:0] ys[6];
    logic         cs[6];
    xs = '{8'h10, 8'h80, 8'h00, 8'h55, 8'h20, 8'h33};
    ys = '{8'h20, 8'h01, 8'h00, 8'h55, 8'h1F, 8'h44};
    cs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 4; i < 6; i++) begin
      xs[i] = W'($urandom);
      ys[i] = W'($urandom);
    end
    run_table("sub", 1'b1, xs, ys, cs);
  endtask

  // start held high with fresh operands every cycle: one accept per W+2 edges.
  task automatic test_back_to_back;
    exp_t e;
    int   ndone = 0;
    logic m, ci;
    logic [W-1:0] x, y;
    for (int n = 0; n < 5 * (W + 2); n++) begin
      @(negedge clk);
      checks++;
      if (done !== ((n % (W + 2)) == W + 1)) begin
        errors++;
        $display("FAIL b2b_done_timing cycle %0d got %b required %b", n, done,
                 ((n % (W + 2)) == W + 1));
      end
      if (done === 1'b1) begin
        ndone++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_queue empty at done, cycle %0d", n);
        end else begin
          e = q.pop_front();
          checks++;
          if (result !== e.r || cbo !== e.c) begin
            errors++;
            $display("FAIL b2b_result cycle %0d got %h/%b required %h/%b",
                     n, result, cbo, e.r, e.c);
          end
          last_result = e.r;
        end
      end
      m     = 1'($urandom);
      ci    = 1'($urandom);
      x     = W'($urandom);
      y     = W'($urandom);
      mode  = m;
      cin   = ci;
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      if ((n % (W + 2)) == 0) q.push_back(model(m, x, y, ci));
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (ndone != 5) begin
      errors++;
      $display("FAIL b2b_done_count got %0d required 5", ndone);
    end
    repeat (W + 4) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int   cyc;
    logic held;
    logic seen = 1'b0;
    exp_t e;
    issue(1'b0, 8'h77, 8'h11, 1'b0);
    repeat (5) @(negedge clk);
    resetN = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || result !== '0 || done !== 1'b0 || cbo !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_immediate busy=%b result=%h done=%b cbo=%b required 0",
               busy, result, done, cbo);
    end
    if (q.size() != 0) void'(q.pop_front());
    last_result = '0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_no_done got activity after abort required none");
    end
    issue(1'b0, 8'h02, 8'h03, 1'b0);
    wait_done(cyc, held);
    checks++;
    if (cyc != W + 1) begin
      errors++;
      $display("FAIL reset_mid_rerun_latency got %0d required %0d", cyc, W + 1);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (result !== e.r || cbo !== e.c) begin
        errors++;
        $display("FAIL reset_mid_rerun got %h/%b required %h/%b", result, cbo, e.r, e.c);
      end
      last_result = e.r;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
